// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Memory-stage data-memory controller for the RV32 pipeline. It turns a
//   load/store from EX/MEM into a word-aligned req/ack transaction with byte
//   strobes, and it stalls the pipeline while the request is outstanding.
//   Load data comes back right-aligned and zero-filled. Sign/zero extension
//   is left to writeback.
//
// Parameters
//   TIMEOUT  maximum number of BUSY cycles to wait for mem_ack (1..255)
//   CNT_W    width of the timeout counter
//
// Ports
//   clk, reset_n              clock (rising edge), async active-low reset
//   memRead, memWrite         load / store request from EX/MEM
//   aluSelect[5:0]            op code (LB..LHU loads, SB..SW stores)
//   address[31:0]             byte address from the ALU
//   storeData[31:0]           rs2 store operand (low bits)
//   mem_req, mem_we           memory request, write enable
//   mem_addr[31:0]            word address
//   mem_wdata[31:0]           lane-replicated store data
//   mem_wstrb[3:0]            byte-lane write enables (0 on reads)
//   mem_ack, mem_rdata[31:0]  completion pulse and read word
//   loadData[31:0], loadValid right-aligned load result and its valid pulse
//   stall                     freeze IF/ID/EX/MEM
//   misaligned, bus_error     one-cycle fault pulses
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [5:0]  aluSelect,
  input  logic [31:0] address,
  input  logic [31:0] storeData,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] loadData,
  output logic        loadValid,
  output logic        stall,
  output logic        misaligned,
  output logic        bus_error
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [5:0] OP_LB  = 6'b001011;
  localparam logic [5:0] OP_LH  = 6'b001100;
  localparam logic [5:0] OP_LW  = 6'b001101;
  localparam logic [5:0] OP_LBU = 6'b001110;
  localparam logic [5:0] OP_LHU = 6'b001111;
  localparam logic [5:0] OP_SB  = 6'b010000;
  localparam logic [5:0] OP_SH  = 6'b010001;
  localparam logic [5:0] OP_SW  = 6'b010010;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [5:0]       op_q;
  logic [1:0]       off_q;

  logic        is_load_op, is_store_op, is_half, is_word;
  logic        misal, illegal, any_req, accept;
  logic [31:0] wdata_n;
  logic [3:0]  wstrb_n;
  logic [31:0] rd_shift, rd_aligned;

  // Request decode
  always_comb begin
    is_load_op  = (aluSelect == OP_LB) || (aluSelect == OP_LH) || (aluSelect == OP_LW) ||
                  (aluSelect == OP_LBU) || (aluSelect == OP_LHU);
    is_store_op = (aluSelect == OP_SB) || (aluSelect == OP_SH) || (aluSelect == OP_SW);
    is_half     = (aluSelect == OP_LH) || (aluSelect == OP_LHU) || (aluSelect == OP_SH);
    is_word     = (aluSelect == OP_LW) || (aluSelect == OP_SW);
    misal       = (is_half && address[0]) || (is_word && (address[1:0] != 2'b00));
    any_req     = memRead || memWrite;
    // Both directions at once, or an op code that belongs to the other direction
    illegal     = (memRead && memWrite) ||
                  (memRead && !memWrite && !is_load_op) ||
                  (memWrite && !memRead && !is_store_op);
    accept      = (state == IDLE) && any_req && !illegal && !misal;
    // Gated by reset so the pipeline is released as soon as reset asserts
    stall       = reset_n && (accept || (state == BUSY));
  end

  // Store lane replication and strobes
  always_comb begin
    wdata_n = '0;
    wstrb_n = '0;
    case (aluSelect)
      OP_SB: begin
        wdata_n = {4{storeData[7:0]}};
        wstrb_n = 4'b0001 << address[1:0];
      end
      OP_SH: begin
        wdata_n = {2{storeData[15:0]}};
        wstrb_n = 4'b0011 << address[1:0];
      end
      OP_SW: begin
        wdata_n = storeData;
        wstrb_n = 4'b1111;
      end
      default: begin
        wdata_n = '0;
        wstrb_n = '0;
      end
    endcase
  end

  // Load alignment
  always_comb begin
    rd_shift   = mem_rdata >> {off_q, 3'b000};
    rd_aligned = mem_rdata;
    case (op_q)
      OP_LB, OP_LBU: rd_aligned = {24'h000000, rd_shift[7:0]};
      OP_LH, OP_LHU: rd_aligned = {16'h0000, rd_shift[15:0]};
      default:       rd_aligned = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      op_q       <= '0;
      off_q      <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
      loadData   <= '0;
      loadValid  <= 1'b0;
      misaligned <= 1'b0;
      bus_error  <= 1'b0;
    end else begin
      loadValid  <= 1'b0;
      misaligned <= 1'b0;
      bus_error  <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            if (illegal) begin
              bus_error <= 1'b1;
            end else if (misal) begin
              misaligned <= 1'b1;
            end else begin
              state     <= BUSY;
              cnt       <= '0;
              op_q      <= aluSelect;
              off_q     <= address[1:0];
              mem_req   <= 1'b1;
              mem_we    <= memWrite;
              mem_addr  <= {address[31:2], 2'b00};
              mem_wdata <= wdata_n;
              mem_wstrb <= wstrb_n;
            end
          end
        end
        BUSY: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            cnt     <= '0;
            state   <= DONE;
            if (!mem_we) begin
              loadData  <= rd_aligned;
              loadValid <= 1'b1;
            end
          end else if (cnt == CNT_LAST) begin
            mem_req   <= 1'b0;
            cnt       <= '0;
            bus_error <= 1'b1;
            loadData  <= '0;
            state     <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  localparam int unsigned TO = 4;

  localparam logic [5:0] LB  = 6'b001011;
  localparam logic [5:0] LH  = 6'b001100;
  localparam logic [5:0] LW  = 6'b001101;
  localparam logic [5:0] LBU = 6'b001110;
  localparam logic [5:0] LHU = 6'b001111;
  localparam logic [5:0] SB  = 6'b010000;
  localparam logic [5:0] SH  = 6'b010001;
  localparam logic [5:0] SW  = 6'b010010;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        memRead = 1'b0;
  logic        memWrite = 1'b0;
  logic [5:0]  aluSelect = '0;
  logic [31:0] address = '0;
  logic [31:0] storeData = '0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] loadData;
  logic        loadValid, stall, misaligned, bus_error;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .memRead(memRead), .memWrite(memWrite),
    .aluSelect(aluSelect), .address(address), .storeData(storeData),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .loadData(loadData), .loadValid(loadValid), .stall(stall),
    .misaligned(misaligned), .bus_error(bus_error)
  );

  int total = 0;
  int bad = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  // kind: 0 unknown, 1 load, 2 store; size in bytes
  function automatic void op_info(input logic [5:0] op, output int kind, output int size);
    kind = 0; size = 0;
    case (op)
      LB, LBU: begin kind = 1; size = 1; end
      LH, LHU: begin kind = 1; size = 2; end
      LW:      begin kind = 1; size = 4; end
      SB:      begin kind = 2; size = 1; end
      SH:      begin kind = 2; size = 2; end
      SW:      begin kind = 2; size = 4; end
      default: begin kind = 0; size = 0; end
    endcase
  endfunction

  // 0 no request, 1 accepted, 2 misaligned, 3 illegal
  function automatic int classify(input logic rd, input logic wr, input logic [5:0] op,
                                  input logic [31:0] addr);
    int kind, size;
    if (!rd && !wr) return 0;
    if (rd && wr) return 3;
    op_info(op, kind, size);
    if ((rd && kind != 1) || (wr && kind != 2)) return 3;
    if ((addr % size) != 0) return 2;
    return 1;
  endfunction

  // Behavioural model: one outstanding transaction record
  bit          m_busy = 0, m_done = 0, m_load = 0, m_we = 0;
  int          m_age = 0, m_size = 0, m_off = 0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_sh = '0;
  logic [3:0]  m_wstrb = '0;
  logic [31:0] e_ld = '0;
  bit          e_lv = 0, e_mis = 0, e_be = 0;

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      m_busy = 0; m_done = 0; m_age = 0;
      e_ld = '0; e_lv = 0; e_mis = 0; e_be = 0;
    end else begin
      e_lv = 0; e_mis = 0; e_be = 0;
      if (m_done) begin
        m_done = 0;
      end else if (m_busy) begin
        if (mem_ack) begin
          m_busy = 0;
          m_done = 1;
          if (m_load) begin
            m_sh = mem_rdata >> (8 * m_off);
            if (m_size == 1)      e_ld = m_sh & 32'h0000_00ff;
            else if (m_size == 2) e_ld = m_sh & 32'h0000_ffff;
            else                  e_ld = mem_rdata;
            e_lv = 1;
          end
        end else begin
          m_age++;
          if (m_age == TO) begin
            m_busy = 0;
            e_be = 1;
            e_ld = '0;
          end
        end
      end else begin
        case (classify(memRead, memWrite, aluSelect, address))
          3: e_be = 1;
          2: e_mis = 1;
          1: begin
            int kind;
            op_info(aluSelect, kind, m_size);
            m_busy = 1;
            m_age = 0;
            m_load = memRead;
            m_we = memWrite;
            m_off = int'(address[1:0]);
            m_addr = address & 32'hffff_fffc;
            if (m_size == 1)      m_wdata = {4{storeData[7:0]}};
            else if (m_size == 2) m_wdata = {2{storeData[15:0]}};
            else                  m_wdata = storeData;
            m_wstrb = m_load ? 4'b0000 : 4'(((1 << m_size) - 1) << m_off);
          end
          default: ;
        endcase
      end
    end
  end

  // Compare process: every cycle, away from the active edge
  initial forever begin
    bit exp_stall;
    @(negedge clk);
    exp_stall = reset_n && (m_busy ||
                (!m_done && classify(memRead, memWrite, aluSelect, address) == 1));
    check1("mem_req", mem_req, m_busy);
    check1("stall", stall, exp_stall);
    check1("loadValid", loadValid, e_lv);
    check1("misaligned", misaligned, e_mis);
    check1("bus_error", bus_error, e_be);
    check32("loadData", loadData, e_ld);
    if (m_busy) begin
      check1("mem_we", mem_we, m_we);
      check32("mem_addr", mem_addr, m_addr);
      check32("mem_wstrb", 32'(mem_wstrb), 32'(m_wstrb));
      if (m_we) check32("mem_wdata", mem_wdata, m_wdata);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_in();
    memRead = 0; memWrite = 0; mem_ack = 0;
  endtask

  logic [5:0] legal_ops [8] = '{LB, LH, LW, LBU, LHU, SB, SH, SW};

  initial begin
    // Reset state
    cyc(); cyc();
    #1;
    check1("rst_req", mem_req, 1'b0);
    check1("rst_we", mem_we, 1'b0);
    check32("rst_addr", mem_addr, 32'h0);
    check32("rst_wdata", mem_wdata, 32'h0);
    check32("rst_wstrb", 32'(mem_wstrb), 32'h0);
    check32("rst_ld", loadData, 32'h0);
    check1("rst_lv", loadValid, 1'b0);
    check1("rst_stall", stall, 1'b0);
    reset_n = 1;

    // LB at 0x1003, ack on second BUSY cycle
    cyc(); memRead = 1; aluSelect = LB; address = 32'h1003;
    @(negedge clk); check1("lb_stall0", stall, 1'b1); check1("lb_req0", mem_req, 1'b0);
    cyc(); idle_in();
    @(negedge clk); check1("lb_req1", mem_req, 1'b1); check32("lb_addr", mem_addr, 32'h1000);
    check32("lb_wstrb", 32'(mem_wstrb), 32'h0); check1("lb_stall1", stall, 1'b1);
    cyc(); mem_ack = 1; mem_rdata = 32'hA511_2233;
    @(negedge clk); check1("lb_stall2", stall, 1'b1);
    cyc(); mem_ack = 0; mem_rdata = $urandom;
    @(negedge clk); check1("lb_stall3", stall, 1'b0); check1("lb_lv", loadValid, 1'b1);
    check32("lb_data", loadData, 32'h0000_00A5);
    cyc();
    @(negedge clk); check1("lb_lv_once", loadValid, 1'b0);

    // SH at 0x2002
    cyc(); memWrite = 1; aluSelect = SH; address = 32'h2002; storeData = 32'hDEAD_1234;
    cyc(); idle_in();
    @(negedge clk); check1("sh_we", mem_we, 1'b1); check32("sh_wdata", mem_wdata, 32'h1234_1234);
    check32("sh_wstrb", 32'(mem_wstrb), 32'hC);
    cyc(); mem_ack = 1;
    cyc(); mem_ack = 0;
    @(negedge clk); check1("sh_no_lv", loadValid, 1'b0); check32("sh_ld_hold", loadData, 32'h0000_00A5);

    // LW misaligned at 0x3001
    cyc(); memRead = 1; aluSelect = LW; address = 32'h3001;
    @(negedge clk); check1("mis_stall", stall, 1'b0);
    cyc(); idle_in();
    @(negedge clk); check1("mis_pulse", misaligned, 1'b1); check1("mis_req", mem_req, 1'b0);
    cyc();
    @(negedge clk); check1("mis_once", misaligned, 1'b0); check1("mis_req2", mem_req, 1'b0);

    // LHU at 0x4000 with no ack -> timeout
    cyc(); memRead = 1; aluSelect = LHU; address = 32'h4000;
    cyc(); idle_in();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); check1("to_req", mem_req, 1'b1);
      cyc();
    end
    @(negedge clk); check1("to_req_off", mem_req, 1'b0); check1("to_berr", bus_error, 1'b1);
    check32("to_ld", loadData, 32'h0); check1("to_no_lv", loadValid, 1'b0);
    cyc();
    @(negedge clk); check1("to_berr_once", bus_error, 1'b0);

    // Reset while an LW is BUSY, then a late ack
    cyc(); memRead = 1; aluSelect = LW; address = 32'h5004;
    cyc(); idle_in();
    @(negedge clk); check1("rb_req", mem_req, 1'b1);
    cyc(); reset_n = 0;
    #1; check1("rb_req_drop", mem_req, 1'b0); check1("rb_stall_drop", stall, 1'b0);
    cyc(); mem_ack = 1; mem_rdata = 32'h1111_1111;
    cyc(); reset_n = 1;
    @(negedge clk); check1("rb_late_req", mem_req, 1'b0); check1("rb_late_lv", loadValid, 1'b0);
    cyc(); mem_ack = 0;
    @(negedge clk); check1("rb_late_lv2", loadValid, 1'b0);
    cyc(); memRead = 1; aluSelect = LW; address = 32'h5000;
    cyc(); idle_in(); mem_ack = 1; mem_rdata = 32'hCAFE_BABE;
    cyc(); mem_ack = 0;
    @(negedge clk); check1("rb_lv", loadValid, 1'b1); check32("rb_data", loadData, 32'hCAFE_BABE);

    // Both directions high
    cyc(); memRead = 1; memWrite = 1; aluSelect = LW; address = 32'h0;
    @(negedge clk); check1("both_stall", stall, 1'b0);
    cyc(); idle_in();
    @(negedge clk); check1("both_berr", bus_error, 1'b1); check1("both_req", mem_req, 1'b0);
    cyc();
    @(negedge clk); check1("both_once", bus_error, 1'b0);

    // Randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      int r;
      cyc();
      if (!reset_n) reset_n = 1;
      else if ($urandom_range(0, 599) == 0) reset_n = 0;
      r = $urandom_range(0, 9);
      memRead   = (r < 4) || (r == 8);
      memWrite  = (r >= 4 && r < 8) || (r == 8);
      aluSelect = ($urandom_range(0, 9) < 8) ? legal_ops[$urandom_range(0, 7)] : 6'($urandom);
      address   = $urandom;
      storeData = $urandom;
      mem_rdata = $urandom;
      mem_ack   = m_busy ? ($urandom_range(0, 99) < 35) : ($urandom_range(0, 19) == 0);
    end

    cyc(); reset_n = 1; idle_in();
    cyc(); cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage data-memory controller of the RV32 pipeline; sits between the EX/MEM pipeline register and the data memory, directly upstream of the writeback load converter.
- Issues word-aligned load/store requests with byte strobes over a req/ack handshake and stalls the pipeline while a request is outstanding.
- Returns load data right-aligned: the selected byte/half is in the low bits, upper bits zero. Writeback performs the sign/zero extension.

Parameters:
- TIMEOUT, 16, max cycles to wait for mem_ack before aborting (valid range 1..255).
- CNT_W, 8, width of the timeout counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- memRead  in  1  load request from EX/MEM.
- memWrite  in  1  store request from EX/MEM.
- aluSelect  in  6  op code: LB 001011, LH 001100, LW 001101, LBU 001110, LHU 001111, SB 010000, SH 010001, SW 010010.
- address  in  32  byte address from the ALU.
- storeData  in  32  rs2 value; the operand is in the low bits.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write.
- mem_addr  out  32  word address, {address[31:2], 2'b00}.
- mem_wdata  out  32  lane-replicated store data.
- mem_wstrb  out  4  byte-lane write enables; 0 on reads.
- mem_ack  in  1  memory completion, 1-cycle pulse.
- mem_rdata  in  32  read word, valid while mem_ack is high.
- loadData  out  32  right-aligned load result.
- loadValid  out  1  1-cycle pulse when loadData is valid.
- stall  out  1  freeze IF/ID/EX/MEM registers.
- misaligned  out  1  1-cycle alignment-fault pulse.
- bus_error  out  1  1-cycle timeout or illegal-op pulse.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transaction):
  - state = IDLE.
  - All outputs 0: mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata, loadData, loadValid, misaligned, bus_error.
  - Timeout counter = 0.
  - A pending mem_ack arriving after reset is ignored.
- FSM states: IDLE, BUSY, DONE.
- IDLE, valid aligned request (exactly one of memRead/memWrite set, legal code for that direction, aligned):
  - stall = 1 combinationally in the same cycle.
  - Latch op, offset = address[1:0], mem_addr, mem_wdata and mem_wstrb.
  - Next state BUSY; mem_req = 1 from the next cycle.
- Alignment rules:
  - Halfword ops (LH, LHU, SH) need address[0] = 0.
  - Word ops (LW, SW) need address[1:0] = 0.
  - A violation pulses misaligned for 1 cycle, issues no request, asserts no stall, and the FSM stays in IDLE.
- Illegal requests pulse bus_error for 1 cycle, issue no request and assert no stall. Illegal means either:
  - memRead and memWrite both high, or
  - a code that does not match the asserted direction.
- BUSY:
  - mem_req = 1; mem_we, mem_addr, mem_wdata and mem_wstrb are held stable; stall = 1; the counter increments every cycle.
  - mem_ack = 1: capture the aligned read data (loads only), clear mem_req, reset the counter, next state DONE.
  - Counter reaches TIMEOUT-1 without ack: clear mem_req, pulse bus_error, set loadData = 0, return to IDLE; no loadValid.
- DONE (1 cycle): stall = 0, loadValid = 1 for loads only, then IDLE.
  - The pipeline advances on this edge, so a back-to-back request is accepted in the cycle after DONE.
  - Minimum occupancy is 3 cycles (request, BUSY with same-cycle ack, DONE).
- Load alignment: sh = mem_rdata >> (8*offset).
  - LB/LBU: loadData = {24'b0, sh[7:0]}.
  - LH/LHU: loadData = {16'b0, sh[15:0]}.
  - LW: loadData = mem_rdata.
- Store lanes:
  - SB: wdata = {4{storeData[7:0]}}, wstrb = 4'b0001 << offset.
  - SH: wdata = {2{storeData[15:0]}}, wstrb = 4'b0011 << offset.
  - SW: wdata = storeData, wstrb = 4'b1111.
- loadData holds its last value until the next load completes, a timeout occurs, or reset.

Test Plan:
- LB at 0x1003, mem_rdata = 0xA5112233 with ack on the 2nd BUSY cycle -> mem_addr = 0x1000, wstrb = 0, stall high for 3 cycles, loadData = 0x000000A5, loadValid pulses once.
- SH at 0x2002, storeData = 0xDEAD1234 -> mem_we = 1, mem_wdata = 0x12341234, mem_wstrb = 4'b1100; no loadValid.
- LW at 0x3001 -> misaligned pulses once; mem_req and stall stay 0.
- LHU at 0x4000 with no ack and TIMEOUT = 4 -> mem_req high for 4 cycles, then bus_error pulses, loadData = 0, FSM back in IDLE.
- reset_n pulled low in BUSY during an LW -> mem_req and stall drop immediately; a late mem_ack is ignored; next LW at 0x5000 with mem_rdata = 0xCAFEBABE returns loadData = 0xCAFEBABE.
- memRead and memWrite both high -> bus_error pulses once, no request issued.
